// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM states, frame constants, parity encoding.
// The sample-point helpers are used by uart_rx_fsm in both the plain and UART_RX_MAJORITY_EN builds.
package uart_rx_pkg;

    localparam int DATA_W_DEF = 8;

    // Bit value is registered this many edges after the bit centre (PRESCALE/2).
    localparam int SAMPLE_REG_OFS = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_e;

    // Same encoding the transmit side uses for PAR_TYP.
    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_typ_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Oversampling edge counter (0..PRESCALE-1) and data-bit counter for the UART receiver.
module uart_rx_edge_bit_counter
#(
    parameter int DATA_W     = 8,
    parameter int PRESCALE_W = 6,
    parameter int BIT_W      = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clr_i,
    input  logic                  en_i,
    input  logic                  bit_en_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic [PRESCALE_W-1:0] edge_cnt_o,
    output logic [BIT_W-1:0]      bit_cnt_o,
    output logic                  bit_done_o
);

    logic [PRESCALE_W-1:0] edge_q, edge_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic                  last_edge;

    assign last_edge = (edge_q == (prescale_i - PRESCALE_W'(1)));

    always_comb begin
        edge_d = edge_q;
        bit_d  = bit_q;
        if (clr_i) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (en_i) begin
            edge_d = last_edge ? '0 : edge_q + PRESCALE_W'(1);
            if (bit_en_i && last_edge) begin
                bit_d = (bit_q == BIT_W'(DATA_W - 1)) ? '0 : bit_q + BIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            edge_q <= '0;
            bit_q  <= '0;
        end else begin
            edge_q <= edge_d;
            bit_q  <= bit_d;
        end
    end

    assign edge_cnt_o = edge_q;
    assign bit_cnt_o  = bit_q;
    assign bit_done_o = en_i && last_edge;

endmodule

// File: rtl/uart_rx_fsm.sv
// UART receive controller: start detect, oversampled 8N1/8P1 deserialise, parity and stop check.
// Define UART_RX_MAJORITY_EN for 3-sample majority voting around the bit centre.
module uart_rx_fsm
    import uart_rx_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic [DATA_W-1:0]     P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_e             state_q, state_d;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic                  bit_done;
    logic                  cnt_clr, cnt_en, bit_en;

    logic                  rx_d1_q;
    logic                  bit_val;
    logic                  at_sample;
    logic [PRESCALE_W-1:0] sample_pt;

    logic [DATA_W-1:0]     shift_q, shift_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_err_q, par_err_d;
    logic                  stop_q, stop_d;
    logic [DATA_W-1:0]     pdata_q, pdata_d;
    logic                  dv_q, dv_d;
    logic                  pe_q, pe_d;
    logic                  se_q, se_d;

    uart_rx_edge_bit_counter #(
        .DATA_W    (DATA_W),
        .PRESCALE_W(PRESCALE_W),
        .BIT_W     (BIT_W)
    ) u_cnt (
        .clk_i     (CLK),
        .rst_ni    (RST),
        .clr_i     (cnt_clr),
        .en_i      (cnt_en),
        .bit_en_i  (bit_en),
        .prescale_i(PRESCALE),
        .edge_cnt_o(edge_cnt),
        .bit_cnt_o (bit_cnt),
        .bit_done_o(bit_done)
    );

    // rx_d1_q holds RX_IN from edge PRESCALE/2 when edge_cnt reaches the registration point.
    assign sample_pt = (PRESCALE >> 1) + PRESCALE_W'(SAMPLE_REG_OFS);
    assign at_sample = (edge_cnt == sample_pt);

`ifdef UART_RX_MAJORITY_EN
    logic rx_d2_q;
    always_ff @(posedge CLK) rx_d2_q <= rx_d1_q;
    assign bit_val = maj3(rx_d2_q, rx_d1_q, RX_IN);
`else
    assign bit_val = rx_d1_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        bit_en    = 1'b0;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_err_d = par_err_q;
        stop_d    = stop_q;
        pdata_d   = pdata_q;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!RX_IN) begin
                    state_d   = START;
                    cnt_en    = 1'b1;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_err_d = 1'b0;
                end else begin
                    cnt_clr = 1'b1;
                end
            end
            START: begin
                cnt_en = 1'b1;
                if (at_sample && bit_val) begin
                    state_d = IDLE;
                    cnt_clr = 1'b1;
                end else if (bit_done) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_en = 1'b1;
                bit_en = 1'b1;
                if (at_sample) begin
                    shift_d = {bit_val, shift_q[DATA_W-1:1]};
                end
                if (bit_done && (bit_cnt == BIT_W'(DATA_W - 1))) begin
                    state_d = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                cnt_en = 1'b1;
                if (at_sample) begin
                    par_err_d = bit_val ^ (^shift_q) ^ (par_typ_q == PAR_ODD);
                end
                if (bit_done) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                cnt_en = 1'b1;
                if (at_sample) begin
                    stop_d = bit_val;
                end
                // Outcome is registered here so the pulse lands in the first IDLE cycle.
                if (bit_done) begin
                    state_d = IDLE;
                    dv_d    = stop_q && !par_err_q;
                    pe_d    = par_err_q;
                    se_d    = !stop_q;
                    if (stop_q && !par_err_q) begin
                        pdata_d = shift_q;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= IDLE;
            pdata_q <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pdata_q <= pdata_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end

    always_ff @(posedge CLK) begin
        rx_d1_q   <= RX_IN;
        shift_q   <= shift_d;
        par_en_q  <= par_en_d;
        par_typ_q <= par_typ_d;
        par_err_q <= par_err_d;
        stop_q    <= stop_d;
    end

    assign P_DATA     = pdata_q;
    assign DATA_VALID = dv_q;
    assign PAR_ERR    = pe_q;
    assign STP_ERR    = se_q;

endmodule

// File: doc/uart_rx_fsm.md
# uart_rx_fsm

Receive-side controller for the UART peripheral: detects a start bit on the serial line, oversamples each bit at PRESCALE clocks per bit, deserialises 8 data bits LSB-first, checks optional parity and the stop bit, and delivers a byte with error flags. It is the receive counterpart of the UART transmit path: same frame format, same PAR_EN/PAR_TYP semantics. It feeds the register-file/FIFO side of the system on the same clock.

## Interface
- DATA_W, 8, data bits per frame
- PRESCALE_W, 6, width of PRESCALE input

- CLK  in  1  receiver clock (oversampling clock)
- RST  in  1  reset, synchronous, active-low
- RX_IN  in  1  serial line, idle high, already synchronised to CLK upstream
- PAR_EN  in  1  1 = parity bit present after data
- PAR_TYP  in  1  0 = even, 1 = odd
- PRESCALE  in  PRESCALE_W  clocks per bit; legal values 8, 16, 32
- P_DATA  out  DATA_W  received byte, held until next delivered frame
- DATA_VALID  out  1  one-cycle pulse, frame good
- PAR_ERR  out  1  one-cycle pulse, parity mismatch
- STP_ERR  out  1  one-cycle pulse, stop bit sampled 0

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- edge_cnt runs 0..PRESCALE-1 within each bit; bit_cnt counts data bits 0..7.
- IDLE: on RX_IN==0 -> START; this cycle is edge 0 (edge_cnt<=1 next). PAR_EN/PAR_TYP latched here, held for the whole frame.
- Sample point: bit value registered when edge_cnt == PRESCALE/2+1 (value per Configuration).
- START: if sampled value is 1 -> IDLE at end of the sample cycle (glitch rejected, no flags). Else at edge_cnt==PRESCALE-1 -> DATA.
- DATA: sampled bit shifted in LSB-first; after bit 7 ends -> PARITY if latched PAR_EN, else STOP.
- PARITY: expected = XOR(data) ^ PAR_TYP; mismatch recorded.
- STOP: at edge_cnt==PRESCALE-1 -> IDLE; next cycle pulse outcome:
  - stop==1 and no parity error: DATA_VALID=1, P_DATA updated.
  - parity error: PAR_ERR=1. stop==0: STP_ERR=1. Both may pulse together.
  - any error: DATA_VALID=0, P_DATA unchanged.
- Reset (RST==0 at a CLK edge): state IDLE, counters 0, P_DATA=0, all flags 0; aborts any frame in progress.
- PRESCALE changes mid-frame: undefined; software changes it only while idle.

## Timing
- Cycle 0 = cycle RX_IN first seen low in IDLE. Frame of N bits (10 without parity, 11 with).
- Output pulse at cycle N*PRESCALE; FSM already IDLE in that cycle and may detect the next start bit in it (back-to-back frames, no gap required).
- Flags are registered, exactly one cycle wide.
- Glitch: start bit rejected by cycle PRESCALE/2+2; IDLE and ready next cycle.

## Configuration
- UART_RX_MAJORITY_EN defined: bit value = majority of RX_IN at edge_cnt PRESCALE/2-1, PRESCALE/2, PRESCALE/2+1; single-sample glitches rejected.
- Undefined: bit value = RX_IN at edge_cnt PRESCALE/2 only.
- Sample registration point (PRESCALE/2+1) and all timing are identical in both builds.

## Structure
- Package uart_rx_pkg: state enum (IDLE, START, DATA, PARITY, STOP), DATA_W default, sample-offset constants, parity-type encoding shared with the transmit side.
- Sub-module uart_rx_edge_bit_counter: edge_cnt/bit_cnt with enable, wrap at PRESCALE-1, bit-done strobe. Sampling, deserialising and checking stay in uart_rx_fsm.

## Test plan
- PRESCALE=8, PAR_EN=0, frame 0xA5 -> DATA_VALID at cycle 80, P_DATA=0xA5, no error flags.
- PRESCALE=32, PAR_EN=1, PAR_TYP=0, byte 0x07 with parity bit 1 -> DATA_VALID at cycle 352, P_DATA=0x07. Same with parity bit 0 -> PAR_ERR only, P_DATA unchanged.
- PRESCALE=16, stop bit driven 0 on 0x3C -> STP_ERR at cycle 160, DATA_VALID=0. Bad parity plus bad stop -> PAR_ERR and STP_ERR in the same cycle.
- RX_IN low for 3 cycles in IDLE (PRESCALE=16) -> back to IDLE, no pulses; valid frame immediately after is received correctly.
- Two back-to-back frames 0x55, 0xAA with no idle gap -> two DATA_VALID pulses exactly 10*PRESCALE cycles apart.
- RST low during DATA bit 4, then a new frame 0x81 -> all outputs 0 during reset; 0x81 received correctly. With UART_RX_MAJORITY_EN, a 1-cycle inverted glitch at the centre sample does not corrupt the byte.
